// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch/data) arbiter onto one shared RAM port
// Define MEM_PORT_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t              state_q, state_d;
  logic                port_q, port_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                pick_d;
  logic                d_aligned;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
  logic                last_q, last_d;
`endif

  assign d_aligned = (d_addr[1:0] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      port_q     <= PORT_F;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
      last_q     <= PORT_F;
`endif
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    last_d     = last_q;
    pick_d     = d_req & (~if_req | (last_q == PORT_F));
`else
    pick_d     = d_req;
`endif
    case (state_q)
      ACCESS: begin
        state_d = DONE;
        // Stores and misaligned data accesses return zero data.
        if (port_q == PORT_D) d_rdata_d = (we_q || err_q) ? 32'h0 : mem_rdata;
        else                  if_rdata_d = mem_rdata;
      end
      default: begin
        state_d = IDLE;
        if (if_req || d_req) begin
          state_d = ACCESS;
          if (pick_d) begin
            d_gnt   = 1'b1;
            port_d  = PORT_D;
            addr_d  = d_addr;
            we_d    = d_we & d_aligned;
            wdata_d = d_wdata;
            err_d   = ~d_aligned;
          end else begin
            if_gnt  = 1'b1;
            port_d  = PORT_F;
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            err_d   = 1'b0;
          end
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
          last_d = port_d;
`endif
        end
      end
    endcase
  end

  // Memory port is driven only in ACCESS so reset drops mem_we asynchronously.
  assign mem_addr  = (state_q == ACCESS) ? addr_q  : '0;
  assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
  assign mem_we    = (state_q == ACCESS) & we_q;

  assign if_valid = (state_q == DONE) && (port_q == PORT_F);
  assign d_valid  = (state_q == DONE) && (port_q == PORT_D);
  assign d_err    = d_valid & err_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_valid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;
  int          total = 0;
  int          bad = 0;
  logic        exp_d [0:5];
  logic        exp_f [0:5];

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    step();
    pre_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    preload(8'h40, 32'h007B0293);
    preload(8'h1E, 32'hDEADBEEF);
    preload(8'h10, 32'h0);
    preload(8'h00, 32'h0);
    #1;
    chk("rst_if_gnt", {31'b0, if_gnt}, 32'h0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
    chk("rst_valid", {30'b0, if_valid, d_valid}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_d_err", {31'b0, d_err}, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    step();
    rst = 1'b0;

    // Fetch only
    if_req = 1'b1; if_addr = 32'h100; #1;
    chk("f_gnt", {31'b0, if_gnt}, 32'h1);
    chk("f_d_gnt", {31'b0, d_gnt}, 32'h0);
    step(); if_req = 1'b0; #1;
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we", {31'b0, mem_we}, 32'h0);
    chk("f_gnt_access", {31'b0, if_gnt}, 32'h0);
    chk("f_valid_early", {31'b0, if_valid}, 32'h0);
    step(); #1;
    chk("f_valid", {31'b0, if_valid}, 32'h1);
    chk("f_rdata", if_rdata, 32'h007B0293);
    chk("f_d_valid", {31'b0, d_valid}, 32'h0);
    step(); #1;
    chk("f_valid_once", {31'b0, if_valid}, 32'h0);

    // Misaligned store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h79; d_wdata = 32'h58; #1;
    chk("ms_gnt", {31'b0, d_gnt}, 32'h1);
    step(); d_req = 1'b0; #1;
    chk("ms_mem_we", {31'b0, mem_we}, 32'h0);
    chk("ms_mem_addr", mem_addr, 32'h79);
    step(); #1;
    chk("ms_valid", {31'b0, d_valid}, 32'h1);
    chk("ms_err", {31'b0, d_err}, 32'h1);
    chk("ms_rdata", d_rdata, 32'h0);
    chk("ms_mem_kept", mem[8'h1E], 32'hDEADBEEF);

    // Aligned store
    step();
    d_req = 1'b1; d_addr = 32'h78; #1;
    chk("st_gnt", {31'b0, d_gnt}, 32'h1);
    step(); d_req = 1'b0; #1;
    chk("st_mem_we", {31'b0, mem_we}, 32'h1);
    chk("st_mem_addr", mem_addr, 32'h78);
    chk("st_mem_wdata", mem_wdata, 32'h58);
    step(); #1;
    chk("st_valid", {31'b0, d_valid}, 32'h1);
    chk("st_err", {31'b0, d_err}, 32'h0);
    chk("st_mem_word", mem[8'h1E], 32'h58);

    // Load then back-to-back fetch granted during DONE
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h78; #1;
    chk("ld_gnt", {31'b0, d_gnt}, 32'h1);
    step(); d_req = 1'b0;
    step();
    if_req = 1'b1; if_addr = 32'h100; #1;
    chk("b2b_d_valid", {31'b0, d_valid}, 32'h1);
    chk("b2b_if_gnt", {31'b0, if_gnt}, 32'h1);
    chk("ld_rdata", d_rdata, 32'h58);
    step(); if_req = 1'b0; #1;
    chk("b2b_mem_addr", mem_addr, 32'h100);
    chk("b2b_gnt_access", {31'b0, if_gnt}, 32'h0);
    step(); #1;
    chk("b2b_if_valid", {31'b0, if_valid}, 32'h1);
    chk("b2b_d_valid_off", {31'b0, d_valid}, 32'h0);
    chk("b2b_d_rdata_kept", d_rdata, 32'h58);

    // Reset during store ACCESS
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234; #1;
    chk("ra_gnt", {31'b0, d_gnt}, 32'h1);
    step(); d_req = 1'b0; #1;
    chk("ra_mem_we_on", {31'b0, mem_we}, 32'h1);
    rst = 1'b1; #1;
    chk("ra_mem_we_off", {31'b0, mem_we}, 32'h0);
    step(); rst = 1'b0; #1;
    chk("ra_no_valid", {31'b0, d_valid}, 32'h0);
    chk("ra_mem_untouched", mem[8'h10], 32'h0);
    chk("ra_if_rdata_clr", if_rdata, 32'h0);
    if_req = 1'b1; if_addr = 32'h100; #1;
    chk("ra_next_gnt", {31'b0, if_gnt}, 32'h1);
    step(); if_req = 1'b0;
    step(); #1;
    chk("ra_next_valid", {31'b0, if_valid}, 32'h1);
    chk("ra_next_rdata", if_rdata, 32'h007B0293);
    chk("ra_d_valid", {31'b0, d_valid}, 32'h0);

    // Both ports held from reset
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    exp_d = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_f = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h78; if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("arb_d_gnt_c%0d", k), {31'b0, d_gnt}, {31'b0, exp_d[k]});
      chk($sformatf("arb_if_gnt_c%0d", k), {31'b0, if_gnt}, {31'b0, exp_f[k]});
      step();
    end
    d_req = 1'b0; if_req = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
